// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin mux arbiter.
// The optional grant timeout is selected with the MUX_ARB_TIMEOUT_EN macro.
package mux_arb_pkg;

    localparam int NUM_REQ    = 4;
    localparam int SEL_W      = 2;
    localparam int HOLD_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Rotating priority encoder: finds the first set request bit scanning
// upward from the pointer position, wrapping modulo NUM_REQ.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    // Scan from the farthest offset back to the pointer so the closest hit wins
    always_comb begin
        logic [SEL_W-1:0] cand;
        any    = 1'b0;
        idx    = ptr;
        onehot = '0;
        cand   = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select of a 4:1 mux. It holds a grant
// until the owner signals done, withdraws its request, or (when built with
// MUX_ARB_TIMEOUT_EN) has held the mux for MAX_HOLD cycles, then hands over
// to the next requester without an idle cycle.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy
);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               timeoutHit;
    logic               releaseNow;
    logic [SEL_W-1:0]   pickPtr;
    logic               pickAny;
    logic [SEL_W-1:0]   pickIdx;
    logic [NUM_REQ-1:0] pickOnehot;

`ifdef MUX_ARB_TIMEOUT_EN
    logic [HOLD_CNT_W-1:0] holdCnt_q, holdCnt_d;

    assign timeoutHit = (holdCnt_q == HOLD_CNT_W'(MAX_HOLD - 1));

    // Count cycles of the current grant, restarting on every new grant and saturating
    always_comb begin
        holdCnt_d = holdCnt_q;
        if (state_q == IDLE || releaseNow) begin
            holdCnt_d = '0;
        end else if (holdCnt_q != '1) begin
            holdCnt_d = holdCnt_q + 1'b1;
        end
    end

    // Hold counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            holdCnt_q <= '0;
        end else begin
            holdCnt_q <= holdCnt_d;
        end
    end
`else
    logic [HOLD_CNT_W-1:0] unused_maxHold;

    assign unused_maxHold = HOLD_CNT_W'(MAX_HOLD);
    assign timeoutHit     = 1'b0;
`endif

    // Decide whether the current owner gives up the mux this cycle and where the next scan starts
    always_comb begin
        releaseNow = (state_q == GRANT) && (done || !req[sel_q] || timeoutHit);
        pickPtr    = releaseNow ? sel_q + SEL_W'(1) : ptr_q;
    end

    rr_pick u_pick (
        .req    (req),
        .ptr    (pickPtr),
        .any    (pickAny),
        .idx    (pickIdx),
        .onehot (pickOnehot)
    );

    // Next-state logic: grant from idle, or hand over on release
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    state_d = GRANT;
                    gnt_d   = pickOnehot;
                    sel_d   = pickIdx;
                end
            end
            GRANT: begin
                if (releaseNow) begin
                    ptr_d = pickPtr;
                    if (pickAny) begin
                        gnt_d = pickOnehot;
                        sel_d = pickIdx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = (state_q == GRANT);

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter/scheduler that shares the 4:1 mux datapath between four requesters. It registers a one-hot grant and the matching 2-bit mux select `sel`, and holds the grant until the owner finishes, withdraws, or (optionally) times out. It then rotates priority so no requester starves. It sits directly in front of the 4:1 mux; `sel` drives the mux select input unchanged.

## Interface
- `MAX_HOLD`, default 8: maximum grant length in cycles, legal range 1..255. Used only when the timeout feature is compiled in.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  4  request vector; bit i = requester i wants the mux.
- `done`  in  1  the current owner signals its last cycle of use.
- `gnt`  out  4  registered grant; one-hot or all-zero.
- `sel`  out  2  registered mux select; equals the index of the granted bit while `busy`.
- `busy`  out  1  high while any grant is active.

## Operation
- State machine with two states:
  - IDLE: `gnt`=0 and `busy`=0. `sel` holds its last value.
  - GRANT: exactly one `gnt` bit is set, `busy`=1, and `sel` is stable.
- Priority pointer `ptr[1:0]`: the winner is the first set `req` bit found scanning `ptr`, `ptr`+1, … modulo 4.
- **IDLE → GRANT:** happens when `req`≠0. The winner is loaded into `gnt`/`sel`, `hold_cnt` is set to 0, and the state becomes GRANT.
- **Release condition in GRANT:** `done`=1, OR `req[sel]`=0, OR (timeout enabled AND `hold_cnt`==`MAX_HOLD`-1).
- **On release:**
  - Set `ptr` ← `sel`+1 (wraps 3→0).
  - Re-arbitrate in the same cycle, using the new pointer and the current `req`.
  - If there is a winner, grant it back-to-back with no idle gap and reset `hold_cnt` to 0.
  - If there is no winner, go to IDLE.
- A releasing requester that still holds `req` gets lowest priority. If it is the only requester, it is re-granted immediately.
- Simultaneous release causes are treated as a single release.
- While in GRANT without a release, `hold_cnt` increments and saturates at 255.
- Changes to non-granted `req` bits have no effect while a grant is held.
- **Reset (including mid-grant):** `gnt`=0, `sel`=0, `busy`=0, `ptr`=0, `hold_cnt`=0, state=IDLE.

## Timing
- Grant latency from IDLE is 1 cycle: `req` sampled at edge n gives `gnt`/`sel` valid after edge n.
- Handover latency is 0 idle cycles: a release at edge n makes the new owner visible after edge n.
- `sel` changes only on an edge where `gnt` changes to a non-zero value. It never glitches mid-grant.
- With the timeout enabled, the maximum grant length is exactly `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting requester is 3 grants.

## Configuration
- Macro `MUX_ARB_TIMEOUT_EN`.
- **Defined:** `hold_cnt` and the `MAX_HOLD` release condition are implemented.
- **Undefined:** no counter logic. A grant lasts until `done` or until `req[sel]` drops, and `MAX_HOLD` is ignored.

## Structure
- Package `mux_arb_pkg` holds:
  - `NUM_REQ`=4 and `SEL_W`=2.
  - The state enum `arb_state_t` {IDLE, GRANT}.
  - `HOLD_CNT_W`=8.
- Sub-module `rr_pick` is a combinational rotating priority encoder.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]`, `onehot[3:0]`.
  - It is instantiated once and used for both the IDLE and the release paths.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `sel`=0, `busy`=0 throughout; after the first edge with `rst`=0, `gnt`=4'b0001 and `sel`=0.
- **Single requester:** `req`=4'b0100 held, `done` pulsed on the 3rd grant cycle → `gnt`=4'b0100, `sel`=2 from cycle 1; re-granted to 2 on the next edge with `busy` never dropping.
- **Rotation:** `req`=4'b1111, `done`=1 every cycle → `sel` sequence 0,1,2,3,0,1 on consecutive edges, `busy`=1 continuously.
- **Withdrawal:** owner 1 drops `req[1]` while `req`=4'b1010 → next edge `gnt`=4'b1000, `sel`=3; then with `req`=0 → `gnt`=0, `busy`=0, `sel` stays 3.
- **Timeout:** with `MUX_ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=4'b1111, `done`=0 → each grant lasts exactly 4 cycles, in order 0,1,2,3,0. Without the macro → `gnt` stays 4'b0001 indefinitely.
- **Reset mid-grant:** owner 2, `rst` pulsed for 1 cycle with `req`=4'b1111 → `gnt`=0 after the reset edge, then `gnt`=4'b0001 (pointer back to 0).
